debouncer_bank: RTL and testbench

//  Parametrised N-channel debouncer for board buttons and switches (reset, user buttons, DIP switches).

---
 rtl/debouncer_pkg.sv | 16 +
 rtl/debounce_channel.sv | 73 +++++++
 rtl/debouncer_bank.sv | 106 ++++++++++
 tb/tb_debouncer_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// rtl/debouncer_pkg.sv - shared types and constants for debouncer_bank
// Purpose: edge-mode selector for the pending flags and synchroniser depth.
// Contents:
//   edge_mode_t  which accepted edges set pending flags (rise, fall or both)
//   SYNC_STAGES  flop depth of the optional input synchroniser
package debouncer_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE,
    EDGE_FALL,
    EDGE_BOTH
  } edge_mode_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-channel counter filter with edge pulses
// Purpose: accepts a new level after MAX_COUNT consecutive mismatching samples.
// Ports:
//   clk_i          system clock
//   reset_i        synchronous reset, active-high
//   sample_i       synchronous input sample
//   level_o        debounced stable level
//   rise_o         one-cycle pulse, registered with the 0->1 level change
//   fall_o         one-cycle pulse, registered with the 1->0 level change
//   accept_rise_o  combinational: a 0->1 edge is accepted at the next clock
//   accept_fall_o  combinational: a 1->0 edge is accepted at the next clock
module debounce_channel #(
  parameter int   MAX_COUNT   = 16,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sample_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_rise_o,
  output logic accept_fall_o
);

  localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // The counter only advances while the sample disagrees with the stable
  // level; any agreeing sample restarts filtering. It stops at CNT_LAST,
  // where the new level is taken, so it never wraps.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sample_i != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sample_i;
        rise_d  = sample_i;
        fall_d  = ~sample_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o       = level_q;
  assign rise_o        = rise_q;
  assign fall_o        = fall_q;
  assign accept_rise_o = rise_d;
  assign accept_fall_o = fall_d;

endmodule

// File: rtl/debouncer_bank.sv
// rtl/debouncer_bank.sv - N-channel debouncer with sticky edge flags and IRQ
// Purpose: filters board buttons/switches, reports stable levels, edge pulses,
//   sticky pending flags (filtered by EDGE_MODE) and a masked interrupt.
// Option: DEBOUNCER_SYNC_EN adds a 2-flop synchroniser per channel in front
//   of the filter (2 cycles extra input latency).
// Ports:
//   clk_in          system clock
//   reset_in        synchronous reset, active-high
//   signal_in       raw inputs, one per channel
//   signal_out      debounced stable levels
//   is_rising_out   one-cycle pulse on accepted 0->1
//   is_falling_out  one-cycle pulse on accepted 1->0
//   pending_out     sticky edge flags
//   clear_in        per-channel clear of pending_out
//   irq_mask_in     per-channel interrupt enable
//   irq_out         |(pending_out & irq_mask_in)
module debouncer_bank
  import debouncer_pkg::*;
#(
  parameter int                  CHANNELS    = 8,
  parameter int                  MAX_COUNT   = 16,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0,
  parameter edge_mode_t          EDGE_MODE   = EDGE_BOTH
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] signal_out,
  output logic [CHANNELS-1:0] is_rising_out,
  output logic [CHANNELS-1:0] is_falling_out,
  output logic [CHANNELS-1:0] pending_out,
  input  logic [CHANNELS-1:0] clear_in,
  input  logic [CHANNELS-1:0] irq_mask_in,
  output logic                irq_out
);

  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] accept_rise;
  logic [CHANNELS-1:0] accept_fall;
  logic [CHANNELS-1:0] set_evt;
  logic [CHANNELS-1:0] pending_q, pending_d;

`ifdef DEBOUNCER_SYNC_EN
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

  // Resetting to RESET_VALUE keeps the filter from seeing a spurious
  // mismatch while the chain refills after reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= signal_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];
`else
  assign sample = signal_in;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .MAX_COUNT   (MAX_COUNT),
      .RESET_LEVEL (RESET_VALUE[i])
    ) u_chan (
      .clk_i         (clk_in),
      .reset_i       (reset_in),
      .sample_i      (sample[i]),
      .level_o       (signal_out[i]),
      .rise_o        (is_rising_out[i]),
      .fall_o        (is_falling_out[i]),
      .accept_rise_o (accept_rise[i]),
      .accept_fall_o (accept_fall[i])
    );
  end

  // Pending flags use the channels' accept strobes so a flag sets on the
  // same clock as the level change. Set has priority over clear so an edge
  // arriving with a clear is never lost.
  always_comb begin
    set_evt = '0;
    case (EDGE_MODE)
      EDGE_RISE: set_evt = accept_rise;
      EDGE_FALL: set_evt = accept_fall;
      default:   set_evt = accept_rise | accept_fall;
    endcase
    pending_d = (pending_q & ~clear_in) | set_evt;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_out = pending_q;
  assign irq_out     = |(pending_q & irq_mask_in);

endmodule

// File: tb/tb_debouncer_bank.sv
// tb/tb_debouncer_bank.sv - directed self-checking bench for debouncer_bank
module tb_debouncer_bank;
  import debouncer_pkg::*;

`ifdef DEBOUNCER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int          MAXC  = 4;
  localparam logic [3:0]  RSTV  = 4'b0010;
  localparam int          LAT   = MAXC + SYNC_LAT;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [3:0] signal_in;
  logic [3:0] signal_out;
  logic [3:0] is_rising_out;
  logic [3:0] is_falling_out;
  logic [3:0] pending_out;
  logic [3:0] clear_in;
  logic [3:0] irq_mask_in;
  logic       irq_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debouncer_bank #(
    .CHANNELS    (4),
    .MAX_COUNT   (MAXC),
    .RESET_VALUE (RSTV),
    .EDGE_MODE   (EDGE_BOTH)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .signal_in      (signal_in),
    .signal_out     (signal_out),
    .is_rising_out  (is_rising_out),
    .is_falling_out (is_falling_out),
    .pending_out    (pending_out),
    .clear_in       (clear_in),
    .irq_mask_in    (irq_mask_in),
    .irq_out        (irq_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_in    = 1'b1;
    signal_in   = RSTV;
    clear_in    = '0;
    irq_mask_in = '0;
    tick();
    tick();
    reset_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({signal_out, is_rising_out, is_falling_out, pending_out, irq_out} !==
          {RSTV, 4'b0, 4'b0, 4'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: out=%b rise=%b fall=%b pend=%b irq=%b, expected out=%b others 0",
                 c, signal_out, is_rising_out, is_falling_out, pending_out, irq_out, RSTV);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int rises = 0;
    int rise_at = -1;
    signal_in[0] = 1'b1;
    for (int c = 1; c <= LAT + 6; c++) begin
      tick();
      if (signal_out[0] && first < 0) first = c;
      if (is_rising_out[0]) begin
        rises++;
        rise_at = c;
      end
    end
    checks++;
    if (first !== LAT) begin
      errors++;
      $display("FAIL press_latency: accepted at cycle %0d, expected %0d", first, LAT);
    end
    checks++;
    if (rises !== 1 || rise_at !== LAT) begin
      errors++;
      $display("FAIL press_pulse: %0d pulses last at %0d, expected 1 at %0d", rises, rise_at, LAT);
    end
    checks++;
    if (pending_out !== 4'b0001 || irq_out !== 1'b0) begin
      errors++;
      $display("FAIL press_pending: pend=%b irq=%b, expected pend=0001 irq=0", pending_out, irq_out);
    end
    clear_in[0] = 1'b1;
    tick();
    clear_in[0] = 1'b0;
    checks++;
    if (pending_out !== 4'b0000) begin
      errors++;
      $display("FAIL press_clear: pend=%b, expected 0000", pending_out);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat = 8'b1111_0111;  // bit k applied in cycle k+1
    int falls = 0;
    int first = -1;
    int rises = 0;
    signal_in[0] = 1'b0;
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      if (is_falling_out[0]) falls++;
    end
    checks++;
    if (signal_out[0] !== 1'b0 || falls !== 1) begin
      errors++;
      $display("FAIL bounce_setup: out0=%b falls=%0d, expected out0=0 falls=1", signal_out[0], falls);
    end
    clear_in[0] = 1'b1;
    tick();
    clear_in[0] = 1'b0;
    for (int c = 1; c <= 8 + SYNC_LAT + 5; c++) begin
      signal_in[0] = (c <= 8) ? pat[c-1] : 1'b1;
      tick();
      if (signal_out[0] && first < 0) first = c;
      if (is_rising_out[0]) rises++;
    end
    checks++;
    if (first !== 8 + SYNC_LAT) begin
      errors++;
      $display("FAIL bounce_latency: accepted at cycle %0d, expected %0d", first, 8 + SYNC_LAT);
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL bounce_pulses: %0d rising pulses, expected 1", rises);
    end
    clear_in[0] = 1'b1;
    tick();
    clear_in[0] = 1'b0;
  endtask

  task automatic test_release_fall();
    int falls = 0;
    int fall_at = -1;
    irq_mask_in = 4'b0010;
    signal_in[1] = 1'b0;
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      if (c == LAT - 1) begin
        checks++;
        if (signal_out[1] !== 1'b1 || irq_out !== 1'b0) begin
          errors++;
          $display("FAIL fall_early: out1=%b irq=%b, expected out1=1 irq=0", signal_out[1], irq_out);
        end
      end
      if (is_falling_out[1]) begin
        falls++;
        fall_at = c;
      end
    end
    checks++;
    if (falls !== 1 || fall_at !== LAT || signal_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL fall_pulse: %0d pulses at %0d out1=%b, expected 1 at %0d out1=0",
               falls, fall_at, signal_out[1], LAT);
    end
    checks++;
    if (pending_out !== 4'b0010 || irq_out !== 1'b1) begin
      errors++;
      $display("FAIL fall_irq: pend=%b irq=%b, expected pend=0010 irq=1", pending_out, irq_out);
    end
    irq_mask_in = 4'b1101;
    #1;
    checks++;
    if (irq_out !== 1'b0) begin
      errors++;
      $display("FAIL fall_masked: irq=%b, expected 0", irq_out);
    end
    irq_mask_in = 4'b1111;
    clear_in[1] = 1'b1;
    tick();
    clear_in[1] = 1'b0;
    checks++;
    if (pending_out !== 4'b0000 || irq_out !== 1'b0) begin
      errors++;
      $display("FAIL fall_clear: pend=%b irq=%b, expected 0000 0", pending_out, irq_out);
    end
    irq_mask_in = '0;
  endtask

  task automatic test_collision();
    signal_in[2] = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      if (c == LAT) clear_in[2] = 1'b1;
      tick();
    end
    clear_in[2] = 1'b0;
    checks++;
    if (signal_out[2] !== 1'b1 || pending_out !== 4'b0100) begin
      errors++;
      $display("FAIL collision_set: out2=%b pend=%b, expected out2=1 pend=0100", signal_out[2], pending_out);
    end
    tick();
    checks++;
    if (pending_out !== 4'b0100) begin
      errors++;
      $display("FAIL collision_hold: pend=%b, expected 0100", pending_out);
    end
    clear_in = 4'b1100;
    tick();
    clear_in = '0;
    checks++;
    if (pending_out !== 4'b0000) begin
      errors++;
      $display("FAIL collision_clear: pend=%b, expected 0000", pending_out);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    int rises = 0;
    signal_in[3] = 1'b1;
    for (int c = 1; c < LAT; c++) tick();
    checks++;
    if (signal_out[3] !== 1'b0 || is_rising_out !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_pre: out3=%b rise=%b, expected 0 0000", signal_out[3], is_rising_out);
    end
    signal_in = 4'b1010;
    reset_in  = 1'b1;
    tick();
    reset_in = 1'b0;
    checks++;
    if (signal_out !== RSTV || is_rising_out !== 4'b0000 || is_falling_out !== 4'b0000 || pending_out !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_state: out=%b rise=%b fall=%b pend=%b, expected %b 0000 0000 0000",
               signal_out, is_rising_out, is_falling_out, pending_out, RSTV);
    end
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      if (signal_out[3] && first < 0) first = c;
      if (is_rising_out[3]) rises++;
    end
    checks++;
    if (first !== LAT || rises !== 1) begin
      errors++;
      $display("FAIL midreset_restart: accepted at %0d with %0d pulses, expected %0d with 1",
               first, rises, LAT);
    end
    checks++;
    if (signal_out !== 4'b1010 || pending_out !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_final: out=%b pend=%b, expected 1010 1000", signal_out, pending_out);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_fall();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
